boot_dn_sink: RTL and testbench

Receiving end of the boot-loader download port inside `pcw_core`. It accepts byte writes from the top-level boot loader (`dn_go`, `dn_wr`, `dn_addr`, `dn_data`), buffers them in a small FIFO, and commits them to the shared main-RAM write port through a req/ack handshake. While a download is in progress it holds the CPU. After the last byte is committed it hands the CPU the execute address latched from `execute_enable`, with a one-cycle start pulse.

---
 rtl/boot_dn_sink.sv | 126 ++++++++++++
 tb/tb_boot_dn_sink.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_dn_sink.sv
// Boot-loader download sink: buffers loader byte writes in a small FIFO, commits
// them to main RAM over a req/ack port, and holds then starts the CPU.
module boot_dn_sink #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 16
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              dn_go,
    input  logic              dn_wr,
    input  logic [ADDR_W-1:0] dn_addr,
    input  logic [7:0]        dn_data,
    input  logic [15:0]       execute_addr,
    input  logic              execute_enable,
    output logic              ram_req,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_data,
    input  logic              ram_ack,
    output logic              cpu_hold,
    output logic              cpu_start,
    output logic [15:0]       start_addr,
    output logic [15:0]       byte_count,
    output logic [7:0]        checksum,
    output logic              overflow
);
    localparam int             PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, START} state_t;

    state_t               state_q, state_d;
    logic                 go_q, go_qq;
    logic                 drain_first_q;
    logic                 exec_pending_q;
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]       count_q;
    logic [ADDR_W+7:0]    mem_q [FIFO_DEPTH];
    logic [15:0]          byte_count_q;
    logic [7:0]           checksum_q;
    logic                 overflow_q;
    logic [15:0]          start_addr_q;

    logic                 go_rise, accept, fifo_empty, pop, push, drop, exec_latch;
    logic [ADDR_W+7:0]    head;

    assign go_rise    = go_q & ~go_qq;
    assign fifo_empty = (count_q == '0);
    assign head       = mem_q[rd_ptr_q];
    // Strobes count in LOAD and in the single DRAIN cycle that follows it.
    assign accept     = (state_q == LOAD) | ((state_q == DRAIN) & drain_first_q);
    assign exec_latch = execute_enable & ((state_q == LOAD) | (state_q == DRAIN));

    assign ram_req  = ((state_q == LOAD) | (state_q == DRAIN)) & ~fifo_empty;
    assign pop      = ram_req & ram_ack;
    assign push     = dn_wr & accept & ((count_q != DEPTH_C) | pop);
    assign drop     = dn_wr & accept & ~push;
    assign ram_addr = ram_req ? head[ADDR_W+7:8] : '0;
    assign ram_data = ram_req ? head[7:0] : '0;

    assign cpu_hold   = (state_q != IDLE);
    assign cpu_start  = (state_q == START);
    assign start_addr = start_addr_q;
    assign byte_count = byte_count_q;
    assign checksum   = checksum_q;
    assign overflow   = overflow_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (go_rise) state_d = LOAD;
            LOAD:  if (execute_enable | ~dn_go) state_d = DRAIN;
            DRAIN: if (fifo_empty & ~push)
                       state_d = (exec_pending_q | execute_enable) ? START : IDLE;
            START: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            go_q           <= 1'b0;
            go_qq          <= 1'b0;
            drain_first_q  <= 1'b0;
            exec_pending_q <= 1'b0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            byte_count_q   <= '0;
            checksum_q     <= '0;
            overflow_q     <= 1'b0;
            start_addr_q   <= '0;
        end else begin
            state_q       <= state_d;
            go_q          <= dn_go;
            go_qq         <= go_q;
            drain_first_q <= (state_q == LOAD) & (state_d == DRAIN);
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
            if ((state_q == IDLE) & go_rise) begin
                byte_count_q   <= '0;
                checksum_q     <= '0;
                overflow_q     <= 1'b0;
                exec_pending_q <= 1'b0;
            end else begin
                if (push) begin
                    byte_count_q <= byte_count_q + 16'd1;
                    checksum_q   <= checksum_q + dn_data;
                end
                if (drop) overflow_q <= 1'b1;
                if (exec_latch) exec_pending_q <= 1'b1;
            end
            if (exec_latch) start_addr_q <= execute_addr;
        end
    end

    // Buffer storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk_sys) begin
        if (push) mem_q[wr_ptr_q] <= {dn_addr, dn_data};
    end
endmodule

// File: tb/tb_boot_dn_sink.sv
// Self-checking bench for boot_dn_sink: queue-based reference model compared every
// cycle, plus directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_boot_dn_sink;
    localparam int DEPTH = 4;
    localparam int AW    = 16;

    logic          clk_sys = 1'b0;
    logic          reset_n = 1'b0;
    logic          dn_go = 1'b0, dn_wr = 1'b0, ram_ack = 1'b0, execute_enable = 1'b0;
    logic [AW-1:0] dn_addr = '0;
    logic [7:0]    dn_data = '0;
    logic [15:0]   execute_addr = '0;
    logic          ram_req, cpu_hold, cpu_start, overflow;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_data, checksum;
    logic [15:0]   start_addr, byte_count;

    boot_dn_sink #(.FIFO_DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .dn_go(dn_go), .dn_wr(dn_wr),
        .dn_addr(dn_addr), .dn_data(dn_data), .execute_addr(execute_addr),
        .execute_enable(execute_enable), .ram_req(ram_req), .ram_addr(ram_addr),
        .ram_data(ram_data), .ram_ack(ram_ack), .cpu_hold(cpu_hold),
        .cpu_start(cpu_start), .start_addr(start_addr), .byte_count(byte_count),
        .checksum(checksum), .overflow(overflow)
    );

    always #16 clk_sys = ~clk_sys;

    int checks = 0, errors = 0;
    int wr_cnt = 0, start_cnt = 0;
    bit rand_ack = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 loading, 2 draining, 3 starting.
    int               ph = 0;
    logic [AW+7:0]    mq[$];
    logic             g1 = 0, g2 = 0, first = 0, pend = 0, mov = 0;
    logic [15:0]      mbc = 0, msa = 0;
    logic [7:0]       mcs = 0;

    always @(posedge clk_sys or negedge reset_n) begin : model
        bit req, pop, acc, push;
        int nph;
        if (!reset_n) begin
            ph = 0; mq.delete(); g1 = 0; g2 = 0; first = 0; pend = 0;
            mov = 0; mbc = 0; msa = 0; mcs = 0;
        end else begin
            req  = (ph == 1 || ph == 2) && mq.size() > 0;
            pop  = req && ram_ack;
            acc  = (ph == 1) || (ph == 2 && first);
            push = dn_wr && acc && (mq.size() < DEPTH || pop);
            nph  = ph;
            if (ph == 0 && g1 && !g2) begin
                nph = 1; mbc = 0; mcs = 0; mov = 0; pend = 0;
            end else if (ph == 1 && (execute_enable || !dn_go)) nph = 2;
            else if (ph == 2 && mq.size() == 0 && !push) nph = (pend || execute_enable) ? 3 : 0;
            else if (ph == 3) nph = 0;
            if ((ph == 1 || ph == 2) && execute_enable) begin msa = execute_addr; pend = 1; end
            if (dn_wr && acc && !push) mov = 1;
            if (pop) void'(mq.pop_front());
            if (push) begin mq.push_back({dn_addr, dn_data}); mbc = mbc + 1; mcs = mcs + dn_data; end
            first = (ph == 1 && nph == 2);
            g2 = g1; g1 = dn_go;
            ph = nph;
        end
    end

    always @(negedge clk_sys) begin : compare
        logic          ereq;
        logic [AW-1:0] ea;
        logic [7:0]    ed;
        ereq = (ph == 1 || ph == 2) && mq.size() > 0;
        ea   = ereq ? mq[0][AW+7:8] : '0;
        ed   = ereq ? mq[0][7:0] : '0;
        chk("ram_req", ram_req, ereq);
        chk("ram_addr", ram_addr, ea);
        chk("ram_data", ram_data, ed);
        chk("cpu_hold", cpu_hold, ph != 0);
        chk("cpu_start", cpu_start, ph == 3);
        chk("byte_count", byte_count, mbc);
        chk("checksum", checksum, mcs);
        chk("overflow", overflow, mov);
        chk("start_addr", start_addr, msa);
        if (ram_req && ram_ack) wr_cnt++;
        if (cpu_start) start_cnt++;
    end

    task automatic tick();
        @(posedge clk_sys); #1;
        if (rand_ack) ram_ack = 1'($urandom_range(0, 1));
    endtask

    task automatic strobe(input logic [AW-1:0] a, input logic [7:0] d);
        dn_wr = 1; dn_addr = a; dn_data = d; tick(); dn_wr = 0; tick();
    endtask

    task automatic start_load();
        dn_go = 1; tick(); tick(); tick();
    endtask

    task automatic exec(input logic [15:0] a);
        execute_enable = 1; execute_addr = a; tick(); execute_enable = 0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (cpu_hold && n < 3000) begin tick(); n++; end
        if (cpu_hold) begin
            checks++; errors++;
            $display("FAIL %s: cpu_hold still 1 after %0d cycles, expected 0", nm, n);
        end
        dn_go = 0; tick(); tick();
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 3ms");
        $fatal(1);
    end

    initial begin : stim
        int w0, s0, n;
        logic [7:0] d;
        tick(); tick();
        chk("reset ram_req", ram_req, 0);
        chk("reset cpu_hold", cpu_hold, 0);
        chk("reset byte_count", byte_count, 0);
        reset_n = 1; tick();

        // Full boot with zero-wait RAM
        ram_ack = 1; w0 = wr_cnt; s0 = start_cnt;
        start_load();
        chk("load hold", cpu_hold, 1);
        for (int i = 0; i < 276; i++) strobe(16'(i), 8'(i));
        exec(16'h0000);
        wait_idle("boot drain");
        chk("boot writes", wr_cnt - w0, 276);
        chk("boot byte_count", byte_count, 276);
        // sum(0..255) mod 256 = 0x80, sum(0..19) = 0xBE -> 0x3E
        chk("boot checksum", checksum, 8'h3E);
        chk("boot overflow", overflow, 0);
        chk("boot starts", start_cnt - s0, 1);
        chk("boot start_addr", start_addr, 0);

        // Stalled RAM: 8 strobes, 20 cycles without ack
        ram_ack = 0; w0 = wr_cnt; s0 = start_cnt;
        start_load();
        for (int i = 0; i < 8; i++) strobe(16'h1000 + 16'(i), 8'h10 + 8'(i));
        tick(); tick(); tick(); tick();
        chk("stall head addr", ram_addr, 16'h1000);
        chk("stall head data", ram_data, 8'h10);
        chk("stall byte_count", byte_count, 4);
        chk("stall overflow", overflow, 1);
        exec(16'h1234);
        ram_ack = 1;
        wait_idle("stall drain");
        chk("stall writes", wr_cnt - w0, 4);
        chk("stall starts", start_cnt - s0, 1);
        chk("stall start_addr", start_addr, 16'h1234);

        // Push and pop together on a full FIFO
        ram_ack = 0; w0 = wr_cnt; s0 = start_cnt;
        start_load();
        for (int i = 0; i < 4; i++) strobe(16'h2000 + 16'(i), 8'h20 + 8'(i));
        dn_wr = 1; dn_addr = 16'h2004; dn_data = 8'h24; ram_ack = 1; tick();
        dn_wr = 0; ram_ack = 0; tick();
        chk("pp byte_count", byte_count, 5);
        chk("pp overflow", overflow, 0);
        chk("pp head addr", ram_addr, 16'h2001);
        ram_ack = 1; dn_go = 0;
        wait_idle("pp drain");
        chk("pp writes", wr_cnt - w0, 5);
        chk("pp starts", start_cnt - s0, 0);

        // Abort without execute, random RAM latency
        rand_ack = 1; w0 = wr_cnt; s0 = start_cnt;
        start_load();
        for (int i = 0; i < 10; i++) begin
            strobe(16'h3000 + 16'(i), 8'($urandom));
            tick(); tick();
        end
        dn_go = 0;
        wait_idle("abort drain");
        rand_ack = 0; ram_ack = 0;
        chk("abort writes", wr_cnt - w0, 10);
        chk("abort starts", start_cnt - s0, 0);
        chk("abort hold", cpu_hold, 0);

        // Mid-load reset
        start_load();
        for (int i = 0; i < 5; i++) strobe(16'h4000 + 16'(i), 8'h40 + 8'(i));
        reset_n = 0; dn_go = 0; #2;
        chk("rst ram_req", ram_req, 0);
        chk("rst byte_count", byte_count, 0);
        chk("rst checksum", checksum, 0);
        chk("rst cpu_hold", cpu_hold, 0);
        chk("rst start_addr", start_addr, 0);
        tick(); reset_n = 1; tick(); tick();
        ram_ack = 1;
        start_load();
        strobe(16'h5000, 8'h11); strobe(16'h5001, 8'h22); strobe(16'h5002, 8'h33);
        dn_go = 0;
        wait_idle("reload drain");
        chk("reload byte_count", byte_count, 3);
        chk("reload checksum", checksum, 8'h66);

        // Stray inputs while idle
        w0 = wr_cnt; s0 = start_cnt;
        dn_wr = 1; dn_addr = 16'hAAAA; dn_data = 8'h55;
        execute_enable = 1; execute_addr = 16'hBEEF;
        tick(); dn_wr = 0; execute_enable = 0; tick(); tick();
        chk("stray writes", wr_cnt - w0, 0);
        chk("stray starts", start_cnt - s0, 0);
        chk("stray start_addr", start_addr, 0);
        chk("stray byte_count", byte_count, 3);

        // Randomized loads
        rand_ack = 1;
        for (int r = 0; r < 8; r++) begin
            start_load();
            n = $urandom_range(1, 20);
            for (int i = 0; i < n; i++) begin
                d = 8'($urandom);
                dn_wr = 1; dn_addr = 16'($urandom); dn_data = d; tick(); dn_wr = 0;
                repeat ($urandom_range(0, 2)) tick();
            end
            if ($urandom_range(0, 1) == 1) begin
                dn_wr = 1'($urandom_range(0, 1)); dn_addr = 16'($urandom); dn_data = 8'($urandom);
                exec(16'($urandom));
                dn_wr = 0;
                if ($urandom_range(0, 1) == 1) exec(16'($urandom));
            end else begin
                dn_go = 0;
            end
            wait_idle("random drain");
        end
        rand_ack = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
